alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single combinational ALU between NREQ requesters (e.g. control unit, address gen).
//  Round-robin arbitration; latches the winner's mode/operands, drives the ALU for one cycle,
//  registers result+flags and returns a one-cycle done pulse to the winner.
// PARAMETERS
//  NREQ   2   number of requesters, 2..4
// PORTS
//  clk        in   1        single clock, all state on rising edge
//  rst        in   1        synchronous, active-high reset
//  req        in   NREQ     per-requester request level
//  mode_in    in   4*NREQ   ALU mode, requester i at [4i+3:4i]
//  op1_in     in   8*NREQ   Operand1, requester i at [8i+7:8i]
//  op2_in     in   8*NREQ   Operand2, requester i at [8i+7:8i]
//  lock       in   NREQ     (ALU_ARB_LOCK_EN only) hold grant for back-to-back ops
//  gnt        out  NREQ     one-hot, registered; high 1 cycle when winner's inputs latched
//  done       out  NREQ     one-hot, registered; high 1 cycle when result/flags valid
//  result     out  8        captured ALU Out; holds until next capture
//  flags      out  4        captured ALU flags {Z,C,S,O}; holds until next capture
//  alu_e      out  1        ALU enable
//  alu_mode   out  4        ALU Mode
//  alu_op1    out  8        ALU Operand1
//  alu_op2    out  8        ALU Operand2
//  alu_out    in   8        ALU Out
//  alu_flags  in   4        ALU flags
// BEHAVIOUR
//  - Reset: state=IDLE, rr_ptr=0, gnt=0, done=0, result=0, flags=0, alu_e=0, alu_mode/op1/op2=0.
//  - FSM: IDLE -> ISSUE -> DONE -> (ISSUE if any req else IDLE).
//  - Arbitration evaluated only in IDLE and DONE; winner = first set req scanning from rr_ptr
//    upward with wrap (rr_ptr=0: requester 0 highest). On that edge: latch winner's
//    mode/op1/op2 into alu_mode/op1/op2, gnt[winner]<=1, state<=ISSUE, rr_ptr<=winner+1 (mod NREQ).
//  - ISSUE (1 cycle): alu_e=1, gnt high; end of cycle result<=alu_out, flags<=alu_flags,
//    done[winner]<=1, state<=DONE.
//  - DONE (1 cycle): done high, alu_e=0, ALU inputs hold. Re-arbitrate same edge.
//  - Latency: req seen in IDLE at cycle T -> gnt T+1 -> done T+2. Back-to-back: one op / 2 cycles.
//  - Handshake: requester holds req+inputs stable until gnt; drops req in cycle after gnt unless
//    issuing another op. Inputs sampled only at arbitration edge; later changes ignored.
//  - req high during ISSUE is not arbitrated until DONE; no request lost, none double-granted.
//  - Flags passed raw; C and O are meaningful only for arithmetic modes (0000,0001,0111,1000,
//    1001,1111); Z and S valid for all modes.
//  - gnt and done never high in same cycle for the same requester; at most one bit of each set.
//  - Reset mid-op (ISSUE or DONE): op discarded, no done emitted, all outputs to reset values
//    next cycle.
//  - No req: stays IDLE, alu_e=0, outputs stable.
// CONFIGURATION
//  ALU_ARB_LOCK_EN defined: lock port present; in DONE, if lock[winner] && req[winner], same
//    requester re-granted, rr_ptr unchanged; lock ignored in IDLE.
//  ALU_ARB_LOCK_EN undefined: no lock port; pure round-robin.
// TESTING
//  1 rst, req=01, mode0=0000, op1=8'h7F, op2=8'h01 -> gnt=01 @T+1, done=01 @T+2,
//    result=8'h80, flags=4'b0011 (Z=0,C=0,S=1,O=1).
//  2 req=11 from reset, both mode=0001, r0 ops 5,5; r1 ops 3,1 -> r0 done result=0 flags Z=1,
//    then r1 done result=8'h02; gnt order 01,10 with 2-cycle spacing.
//  3 req=11 held for 6 ops -> grants alternate 01,10,01,10,...; never two consecutive to one
//    requester.
//  4 rst asserted in ISSUE of op mode=1000 op2=8'hFF -> no done, result=0, flags=0, alu_e=0
//    next cycle; fresh req afterwards completes normally (result 8'h00, Z=1, C=1).
//  5 op inputs changed in cycle after gnt (op2 8'h10 -> 8'h20, mode 1100, op1=1) ->
//    result=8'h20 from latched 8'h10.
//  6 (ALU_ARB_LOCK_EN) req=11, lock=01 -> r0 granted 3 ops consecutively; drop lock -> r1 next.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between NREQ requesters.
// The winner's mode/operands are latched at the arbitration edge. The ALU is enabled for one
// ISSUE cycle. Result and flags are then captured, and a one-cycle done pulse goes back to the winner.
// Handshake: a requester holds req and its inputs stable until it sees gnt. Inputs are sampled
// only on the arbitration edge. gnt is high during ISSUE and done is high during DONE, so
// neither can be high in the same cycle for the same requester.
// Optional feature macro: ALU_ARB_LOCK_EN adds the lock port. With it, a locked winner that
// keeps requesting is re-granted from DONE without moving the round-robin pointer.
module alu_arbiter #(
    parameter int NREQ = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] mode_in,
    input  logic [8*NREQ-1:0] op1_in,
    input  logic [8*NREQ-1:0] op2_in,
`ifdef ALU_ARB_LOCK_EN
    input  logic [NREQ-1:0]   lock,
`endif
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [7:0]        result,
    output logic [3:0]        flags,
    output logic              alu_e,
    output logic [3:0]        alu_mode,
    output logic [7:0]        alu_op1,
    output logic [7:0]        alu_op2,
    input  logic [7:0]        alu_out,
    input  logic [3:0]        alu_flags,
    output logic [1:0]        dbg_state
);

    localparam int PW = (NREQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [PW-1:0]   cur_q, cur_d;
    logic [NREQ-1:0] gnt_d, done_d;
    logic [7:0]      result_d;
    logic [3:0]      flags_d;
    logic [3:0]      mode_d;
    logic [7:0]      op1_d, op2_d;

    logic            found;
    logic            hold;
    logic [PW-1:0]   win;
    int              cand;
    logic [3:0]      mode_sel;
    logic [7:0]      op1_sel, op2_sel;

    // Pick the first requesting index at or above rr_q, wrapping; lock may override.
    always_comb begin
        found = 1'b0;
        hold  = 1'b0;
        win   = rr_q;
        cand  = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(rr_q) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!found && req[PW'(cand)]) begin
                found = 1'b1;
                win   = PW'(cand);
            end
        end
`ifdef ALU_ARB_LOCK_EN
        if (state_q == DONE && lock[cur_q] && req[cur_q]) begin
            hold  = 1'b1;
            found = 1'b1;
            win   = cur_q;
        end
`endif
    end

    // Select the winner's mode and operands from the packed request buses.
    always_comb begin
        mode_sel = '0;
        op1_sel  = '0;
        op2_sel  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == PW'(i)) begin
                mode_sel = mode_in[4*i +: 4];
                op1_sel  = op1_in[8*i +: 8];
                op2_sel  = op2_in[8*i +: 8];
            end
        end
    end

    // Next-state and next-output logic; everything holds unless the state says otherwise.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        cur_d    = cur_q;
        gnt_d    = '0;
        done_d   = '0;
        result_d = result;
        flags_d  = flags;
        mode_d   = alu_mode;
        op1_d    = alu_op1;
        op2_d    = alu_op2;
        case (state_q)
            IDLE, DONE: begin
                if (found) begin
                    state_d    = ISSUE;
                    cur_d      = win;
                    gnt_d[win] = 1'b1;
                    mode_d     = mode_sel;
                    op1_d      = op1_sel;
                    op2_d      = op2_sel;
                    if (!hold) begin
                        rr_d = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                result_d      = alu_out;
                flags_d       = alu_flags;
                done_d[cur_q] = 1'b1;
                state_d       = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            cur_q    <= '0;
            gnt      <= '0;
            done     <= '0;
            result   <= '0;
            flags    <= '0;
            alu_mode <= '0;
            alu_op1  <= '0;
            alu_op2  <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            cur_q    <= cur_d;
            gnt      <= gnt_d;
            done     <= done_d;
            result   <= result_d;
            flags    <= flags_d;
            alu_mode <= mode_d;
            alu_op1  <= op1_d;
            alu_op2  <= op2_d;
        end
    end

    assign alu_e     = (state_q == ISSUE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter (NREQ=2): per-requester op queues drive the ports, expected
// {result,flags} are queued at drive time and popped on done. Build with ALU_ARB_LOCK_EN
// defined to include the lock scenario.
module tb_alu_arbiter;

    localparam int NREQ = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [7:0]  mode_in;
    logic [15:0] op1_in, op2_in;
`ifdef ALU_ARB_LOCK_EN
    logic [1:0]  lock;
`endif
    logic [1:0]  gnt, done;
    logic [7:0]  result;
    logic [3:0]  flags;
    logic        alu_e;
    logic [3:0]  alu_mode;
    logic [7:0]  alu_op1, alu_op2, alu_out;
    logic [3:0]  alu_flags;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [19:0] op_q0[$], op_q1[$];
    logic [11:0] exp_q0[$], exp_q1[$];
    logic [12:0] done_log[$];
    int          gnt_idx_log[$], gnt_cyc_log[$];
    logic [3:0]  modes[7] = '{4'b0000, 4'b0001, 4'b1000, 4'b1100, 4'b0010, 4'b0011, 4'b0100};

    // clock / reset block
    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(NREQ)) dut (
        .clk(clk), .rst(rst), .req(req), .mode_in(mode_in), .op1_in(op1_in), .op2_in(op2_in),
`ifdef ALU_ARB_LOCK_EN
        .lock(lock),
`endif
        .gnt(gnt), .done(done), .result(result), .flags(flags), .alu_e(alu_e),
        .alu_mode(alu_mode), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_out(alu_out), .alu_flags(alu_flags), .dbg_state(dbg_state)
    );

    // Reference ALU: returns {out, Z, C, S, O}
    function automatic logic [11:0] alu_model(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] r;
        logic c, o;
        c = 1'b0; o = 1'b0; s = '0; r = '0;
        case (m)
            4'b0000: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; o = (a[7] == b[7]) && (r[7] != a[7]); end
            4'b0001: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8]; o = (a[7] != b[7]) && (r[7] != a[7]); end
            4'b1000: begin s = {1'b0, b} + 9'd1; r = s[7:0]; c = s[8]; o = (b == 8'h7F); end
            4'b1100: r = b << a[2:0];
            4'b0010: r = a & b;
            4'b0011: r = a | b;
            4'b0100: r = a ^ b;
            default: r = a;
        endcase
        return {r, (r == 8'h00), c, r[7], o};
    endfunction

    assign {alu_out, alu_flags} = alu_model(alu_mode, alu_op1, alu_op2);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // driver tasks
    task automatic load(input int i);
        logic [19:0] o;
        if (i == 0) begin
            o = op_q0.pop_front();
            mode_in[3:0] = o[19:16]; op1_in[7:0] = o[15:8]; op2_in[7:0] = o[7:0];
            exp_q0.push_back(alu_model(o[19:16], o[15:8], o[7:0]));
            req[0] = 1'b1;
        end else begin
            o = op_q1.pop_front();
            mode_in[7:4] = o[19:16]; op1_in[15:8] = o[15:8]; op2_in[15:8] = o[7:0];
            exp_q1.push_back(alu_model(o[19:16], o[15:8], o[7:0]));
            req[1] = 1'b1;
        end
    endtask

    task automatic driver_step();
        if (rst) begin
            req = '0;
        end else begin
            if (gnt[0]) begin
                if (op_q0.size() > 0) load(0); else req[0] = 1'b0;
            end else if (!req[0] && op_q0.size() > 0) load(0);
            if (gnt[1]) begin
                if (op_q1.size() > 0) load(1); else req[1] = 1'b0;
            end else if (!req[1] && op_q1.size() > 0) load(1);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        driver_step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        done_log.delete();
        gnt_idx_log.delete();
        gnt_cyc_log.delete();
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((op_q0.size() > 0 || op_q1.size() > 0 || exp_q0.size() > 0 || exp_q1.size() > 0 || req != 2'b00)
               && n < budget) begin
            cycle();
            n++;
        end
        check("drain_in_budget", 32'(n < budget), 32'd1);
        cycle();
        cycle();
    endtask

    function automatic logic [19:0] rand_op();
        return {modes[$urandom_range(0, 6)], 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
    endfunction

    // scoreboard / protocol monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            check("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
            check("done_onehot", 32'($onehot0(done)), 32'd1);
            check("gnt_done_overlap", 32'(gnt & done), 32'd0);
            check("alu_e_in_issue", 32'(alu_e), 32'(gnt != 2'b00));
            if (gnt != 2'b00) begin
                gnt_idx_log.push_back(gnt[1] ? 1 : 0);
                gnt_cyc_log.push_back(cyc);
            end
            if (done[0]) begin
                if (exp_q0.size() == 0) check("done0_unexpected", 32'd1, 32'd0);
                else check("done0_result", 32'({result, flags}), 32'(exp_q0.pop_front()));
                done_log.push_back({1'b0, result, flags});
            end
            if (done[1]) begin
                if (exp_q1.size() == 0) check("done1_unexpected", 32'd1, 32'd0);
                else check("done1_result", 32'({result, flags}), 32'(exp_q1.pop_front()));
                done_log.push_back({1'b1, result, flags});
            end
        end
    end

    initial begin
        rst = 1'b1; req = '0; mode_in = '0; op1_in = '0; op2_in = '0;
`ifdef ALU_ARB_LOCK_EN
        lock = '0;
`endif
        do_reset();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_alu_e", 32'(alu_e), 32'd0);
        check("rst_alu_in", 32'({alu_mode, alu_op1, alu_op2}), 32'd0);

        // single op latency and result: 7F + 01
        op_q0.push_back({4'b0000, 8'h7F, 8'h01});
        cycle();
        cycle();
        check("t1_gnt", 32'(gnt), 32'd1);
        check("t1_no_early_done", 32'(done), 32'd0);
        cycle();
        check("t1_done", 32'(done), 32'd1);
        check("t1_result", 32'(result), 32'h80);
        check("t1_flags", 32'(flags), 32'b0011);
        wait_drain(20);
        check("t1_idle_alu_e", 32'(alu_e), 32'd0);

        // two simultaneous requesters
        do_reset();
        op_q0.push_back({4'b0001, 8'd5, 8'd5});
        op_q1.push_back({4'b0001, 8'd3, 8'd1});
        wait_drain(50);
        check("t2_done_count", done_log.size(), 2);
        check("t2_grant_count", gnt_idx_log.size(), 2);
        if (done_log.size() == 2 && gnt_idx_log.size() == 2) begin
            check("t2_first_done", 32'(done_log[0]), 32'({1'b0, 8'h00, 4'b1000}));
            check("t2_second_done", 32'(done_log[1]), 32'({1'b1, 8'h02, 4'b0000}));
            check("t2_first_gnt", gnt_idx_log[0], 0);
            check("t2_second_gnt", gnt_idx_log[1], 1);
            check("t2_gnt_spacing", gnt_cyc_log[1] - gnt_cyc_log[0], 2);
        end

        // six back-to-back ops alternate
        do_reset();
        for (int k = 0; k < 3; k++) begin
            op_q0.push_back(rand_op());
            op_q1.push_back(rand_op());
        end
        wait_drain(100);
        check("t3_grant_count", gnt_idx_log.size(), 6);
        if (gnt_idx_log.size() == 6) begin
            for (int k = 0; k < 6; k++) begin
                check("t3_gnt_order", gnt_idx_log[k], k % 2);
                if (k > 0) check("t3_gnt_spacing", gnt_cyc_log[k] - gnt_cyc_log[k-1], 2);
            end
        end

        // reset during ISSUE discards the op
        do_reset();
        op_q0.push_back({4'b1000, 8'h01, 8'hFF});
        cycle();
        cycle();
        check("t4_gnt", 32'(gnt), 32'd1);
        rst = 1'b1;
        cycle();
        check("t4_no_done", 32'(done), 32'd0);
        check("t4_result", 32'(result), 32'd0);
        check("t4_flags", 32'(flags), 32'd0);
        check("t4_alu_e", 32'(alu_e), 32'd0);
        check("t4_gnt_clear", 32'(gnt), 32'd0);
        exp_q0.delete();
        rst = 1'b0;
        done_log.delete();
        op_q0.push_back({4'b1000, 8'h01, 8'hFF});
        wait_drain(30);
        check("t4_fresh_count", done_log.size(), 1);
        if (done_log.size() == 1) check("t4_fresh_done", 32'(done_log[0]), 32'({1'b0, 8'h00, 4'b1100}));

        // inputs changed after gnt are ignored
        do_reset();
        op_q0.push_back({4'b1100, 8'h01, 8'h10});
        cycle();
        cycle();
        check("t5_gnt", 32'(gnt), 32'd1);
        op2_in[7:0] = 8'h20;
        op1_in[7:0] = 8'h03;
        mode_in[3:0] = 4'b0000;
        cycle();
        check("t5_done", 32'(done), 32'd1);
        check("t5_result", 32'(result), 32'h20);
        wait_drain(20);

        // random mixed traffic
        do_reset();
        for (int k = 0; k < 8; k++) begin
            op_q0.push_back(rand_op());
            op_q1.push_back(rand_op());
        end
        wait_drain(200);
        check("rand_done_count", done_log.size(), 16);

`ifdef ALU_ARB_LOCK_EN
        // lock holds the grant on requester 0
        do_reset();
        lock = 2'b01;
        for (int k = 0; k < 3; k++) op_q0.push_back(rand_op());
        op_q1.push_back(rand_op());
        wait_drain(60);
        lock = 2'b00;
        check("t6_grant_count", gnt_idx_log.size(), 4);
        if (gnt_idx_log.size() == 4) begin
            for (int k = 0; k < 3; k++) check("t6_locked_gnt", gnt_idx_log[k], 0);
            check("t6_release_gnt", gnt_idx_log[3], 1);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
